// File: rtl/regfile_cmd_sequencer.sv
// regfile_cmd_sequencer: in-order command FIFO front-end for a 4 x 8-bit register file
//   clock, reset_n                          : clock, async active-low reset
//   cmd_valid/cmd_ready/cmd_write/cmd_address/cmd_data : command input (valid/ready)
//   write_address/write_data/write_en       : regfile write port
//   read_address/read_data                  : regfile read port (combinational read)
//   rsp_valid/rsp_ready/rsp_data            : read response output (valid/ready)
//   busy                                    : commands queued or response pending
module regfile_cmd_sequencer #(
    parameter int CMD_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [1:0] cmd_address,
    input  logic [7:0] cmd_data,
    output logic [1:0] write_address,
    output logic [7:0] write_data,
    output logic       write_en,
    output logic [1:0] read_address,
    input  logic [7:0] read_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       busy
);
    localparam int AW = $clog2(CMD_DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(CMD_DEPTH);
    logic [10:0] fifo [CMD_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0] count;
    logic [10:0] head;
    logic push, issue, head_write;
    assign head = fifo[rd_ptr];
    assign head_write = head[10];
    assign cmd_ready = count < FULL;
    assign push = cmd_valid && cmd_ready;
    // writes never need the response slot, so a stalled client cannot block them
    assign issue = (count != '0) && (head_write || !rsp_valid || rsp_ready);
    assign write_en = issue && head_write;
    assign write_address = head[9:8];
    assign write_data = head[7:0];
    assign read_address = head[9:8];
    assign busy = (count != '0) || rsp_valid;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CMD_DEPTH; i++) fifo[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= {cmd_write, cmd_address, cmd_data};
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) rd_ptr <= rd_ptr + 1'b1;
            count <= (push && !issue) ? count + 1'b1 : (!push && issue) ? count - 1'b1 : count;
        end
    end
    // a read issue reloads the slot even in the same cycle as a handshake
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_data <= '0;
        end else if (issue && !head_write) begin
            rsp_valid <= 1'b1;
            rsp_data <= read_data;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end
endmodule
